// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, address width and R/W bit values.
package i2c_pkg;

  localparam int   I2C_ADDR_WIDTH = 7;
  localparam logic I2C_WRITE      = 1'b0;
  localparam logic I2C_READ       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one open-drain bus line.
// The filtered level only moves after FILTER_LEN identical synchronized samples.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        // Enough agreeing samples: accept the new level and flag the edge.
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: filtered START/STOP detection, 7-bit address match,
// byte shift in/out with ACK handling and optional clock stretching for late read data.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] ADDRESS          = 7'h50,
  parameter bit                        CLOCK_STRETCHING = 1'b1,
  parameter int                        FILTER_LEN       = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  output logic       addressed,
  output logic       mode,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       tx_request,
  input  logic [7:0] data_tx,
  input  logic       tx_valid,
  output logic       nack,
  output logic       stop,
  output logic       busy
);

  logic w_scl_f, w_scl_rise, w_scl_fall;
  logic w_sda_f, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_in(clk_in), .reset(reset), .i_line(scl),
    .o_level(w_scl_f), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_in(clk_in), .reset(reset), .i_line(sda),
    .o_level(w_sda_f), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  i2c_target_state_t r_state, w_state_nx;
  logic [3:0] r_bitcnt, w_bitcnt_nx;
  logic [7:0] r_shift, w_shift_nx, r_tx_byte, w_tx_byte_nx, r_data_rx, w_data_rx_nx;
  logic r_tx_have, w_tx_have_nx, r_tx_pend, w_tx_pend_nx;
  logic r_sda_low, w_sda_low_nx, r_scl_low, w_scl_low_nx;
  logic r_mode, w_mode_nx, r_nack, w_nack_nx, r_busy, w_busy_nx;
  logic r_addressed, w_addressed_nx, r_rx_valid, w_rx_valid_nx;
  logic r_tx_request, w_tx_request_nx, r_stop, w_stop_nx;
  logic w_load;

  logic       w_start, w_stop_det;
  logic [7:0] w_byte_in;

  assign w_start    = w_sda_fall & w_scl_f;
  assign w_stop_det = w_sda_rise & w_scl_f;
  assign w_byte_in  = {r_shift[6:0], w_sda_f};

  always_comb begin
    w_state_nx      = r_state;
    w_bitcnt_nx     = r_bitcnt;
    w_shift_nx      = r_shift;
    w_tx_byte_nx    = r_tx_byte;
    w_tx_have_nx    = r_tx_have;
    w_tx_pend_nx    = r_tx_pend;
    w_data_rx_nx    = r_data_rx;
    w_sda_low_nx    = r_sda_low;
    w_scl_low_nx    = r_scl_low;
    w_mode_nx       = r_mode;
    w_nack_nx       = r_nack;
    w_busy_nx       = r_busy;
    w_addressed_nx  = 1'b0;
    w_rx_valid_nx   = 1'b0;
    w_tx_request_nx = 1'b0;
    w_stop_nx       = 1'b0;
    w_load          = 1'b0;

    // Read data is only accepted while a request is outstanding; a later strobe overwrites.
    if (tx_valid && r_tx_pend) begin
      w_tx_byte_nx = data_tx;
      w_tx_have_nx = 1'b1;
    end

    if (w_start) begin
      w_state_nx   = ST_ADDR;
      w_bitcnt_nx  = 4'd0;
      w_sda_low_nx = 1'b0;
      w_scl_low_nx = 1'b0;
      w_tx_pend_nx = 1'b0;
      w_tx_have_nx = 1'b0;
      w_busy_nx    = 1'b1;
    end else if (w_stop_det) begin
      w_stop_nx    = r_state inside {ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK};
      w_state_nx   = ST_IDLE;
      w_sda_low_nx = 1'b0;
      w_scl_low_nx = 1'b0;
      w_tx_pend_nx = 1'b0;
      w_tx_have_nx = 1'b0;
      w_busy_nx    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nx  = w_byte_in;
            w_bitcnt_nx = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              if (r_state == ST_WR_DATA) begin
                w_data_rx_nx  = w_byte_in;
                w_rx_valid_nx = 1'b1;
                w_state_nx    = ST_WR_ACK;
              end else if (w_byte_in[7:1] == ADDRESS) begin
                w_addressed_nx = 1'b1;
                w_mode_nx      = w_byte_in[0];
                w_state_nx     = ST_ADDR_ACK;
                if (w_byte_in[0] == I2C_READ) begin
                  w_tx_request_nx = 1'b1;
                  w_tx_pend_nx    = 1'b1;
                  w_tx_have_nx    = 1'b0;
                end
              end else begin
                w_state_nx = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          // First falling edge starts the ACK low; the next one ends the 9th clock.
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_sda_low_nx = 1'b1;
              w_bitcnt_nx  = 4'd9;
            end else begin
              w_sda_low_nx = 1'b0;
              w_bitcnt_nx  = 4'd0;
              if (r_state == ST_WR_ACK || r_mode == I2C_WRITE) begin
                w_state_nx = ST_WR_DATA;
              end else begin
                w_state_nx = ST_RD_DATA;
                w_load     = 1'b1;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (r_scl_low) begin
            if (tx_valid && r_tx_pend) begin
              w_scl_low_nx = 1'b0;
              w_shift_nx   = data_tx;
              w_sda_low_nx = ~data_tx[7];
              w_bitcnt_nx  = 4'd1;
              w_tx_pend_nx = 1'b0;
              w_tx_have_nx = 1'b0;
            end
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd0) begin
              w_load = 1'b1;
            end else if (r_bitcnt == 4'd8) begin
              w_sda_low_nx = 1'b0;
              w_state_nx   = ST_RD_ACK;
            end else begin
              w_shift_nx   = {r_shift[6:0], 1'b1};
              w_sda_low_nx = ~r_shift[6];
              w_bitcnt_nx  = r_bitcnt + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            w_nack_nx = w_sda_f;
            if (!w_sda_f) begin
              w_tx_request_nx = 1'b1;
              w_tx_pend_nx    = 1'b1;
              w_tx_have_nx    = 1'b0;
              w_bitcnt_nx     = 4'd0;
              w_state_nx      = ST_RD_DATA;
            end else begin
              w_state_nx = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end

    // Start of a read byte: send latched data, stretch, or fall back to all ones.
    if (w_load) begin
      if (w_tx_have_nx) begin
        w_shift_nx   = w_tx_byte_nx;
        w_sda_low_nx = ~w_tx_byte_nx[7];
        w_bitcnt_nx  = 4'd1;
        w_tx_pend_nx = 1'b0;
        w_tx_have_nx = 1'b0;
      end else if (CLOCK_STRETCHING) begin
        w_scl_low_nx = 1'b1;
      end else begin
        w_shift_nx   = 8'hFF;
        w_sda_low_nx = 1'b0;
        w_bitcnt_nx  = 4'd1;
        w_tx_pend_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_bitcnt <= '0; r_shift <= '0; r_tx_byte <= '0; r_data_rx <= '0;
      r_tx_have <= 1'b0; r_tx_pend <= 1'b0; r_sda_low <= 1'b0; r_scl_low <= 1'b0;
      r_mode <= 1'b0; r_nack <= 1'b0; r_busy <= 1'b0; r_addressed <= 1'b0;
      r_rx_valid <= 1'b0; r_tx_request <= 1'b0; r_stop <= 1'b0;
    end else begin
      r_bitcnt <= w_bitcnt_nx; r_shift <= w_shift_nx; r_tx_byte <= w_tx_byte_nx;
      r_data_rx <= w_data_rx_nx; r_tx_have <= w_tx_have_nx; r_tx_pend <= w_tx_pend_nx;
      r_sda_low <= w_sda_low_nx; r_scl_low <= w_scl_low_nx; r_mode <= w_mode_nx;
      r_nack <= w_nack_nx; r_busy <= w_busy_nx; r_addressed <= w_addressed_nx;
      r_rx_valid <= w_rx_valid_nx; r_tx_request <= w_tx_request_nx; r_stop <= w_stop_nx;
    end
  end

  assign scl        = r_scl_low ? 1'b0 : 1'bz;
  assign sda        = r_sda_low ? 1'b0 : 1'bz;
  assign addressed  = r_addressed;
  assign mode       = r_mode;
  assign data_rx    = r_data_rx;
  assign rx_valid   = r_rx_valid;
  assign tx_request = r_tx_request;
  assign nack       = r_nack;
  assign stop       = r_stop;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on a pulled-up bus with two
// targets (0x50 stretching, 0x2A non-stretching) sharing the lines.
module tb_i2c_target;

  localparam int Q = 10;

  logic clk_in = 1'b0;
  logic reset;
  wire  scl, sda;
  logic m_scl_low = 1'b0, m_sda_low = 1'b0;

  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  always #5 clk_in = ~clk_in;

  logic       addressed, mode, rx_valid, tx_request, tx_valid, nack, stop, busy;
  logic [7:0] data_rx, data_tx;
  logic       a2_addressed, a2_mode, a2_rx_valid, a2_tx_request, a2_nack, a2_stop, a2_busy;
  logic [7:0] a2_data_rx;
  logic [7:0] a2_data_tx = 8'h00;
  logic       a2_tx_valid = 1'b0;

  i2c_target #(.ADDRESS(7'h50), .CLOCK_STRETCHING(1'b1), .FILTER_LEN(3)) dut (
    .clk_in(clk_in), .reset(reset), .scl(scl), .sda(sda),
    .addressed(addressed), .mode(mode), .data_rx(data_rx), .rx_valid(rx_valid),
    .tx_request(tx_request), .data_tx(data_tx), .tx_valid(tx_valid),
    .nack(nack), .stop(stop), .busy(busy)
  );

  i2c_target #(.ADDRESS(7'h2A), .CLOCK_STRETCHING(1'b0), .FILTER_LEN(3)) dut2 (
    .clk_in(clk_in), .reset(reset), .scl(scl), .sda(sda),
    .addressed(a2_addressed), .mode(a2_mode), .data_rx(a2_data_rx), .rx_valid(a2_rx_valid),
    .tx_request(a2_tx_request), .data_tx(a2_data_tx), .tx_valid(a2_tx_valid),
    .nack(a2_nack), .stop(a2_stop), .busy(a2_busy)
  );

  int n_pass = 0, n_tot = 0, n_fail = 0;
  int n_addr, n_txreq, n_stop, n_addr2, n_txreq2;
  int resp_delay, resp_cnt;
  logic       mode_log[$];
  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];
  logic str_mid, str_before, str_after, str_arm_after;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    n_addr = 0; n_txreq = 0; n_stop = 0; n_addr2 = 0; n_txreq2 = 0;
    resp_cnt = 0; str_arm_after = 1'b0;
    mode_log.delete(); rx_log.delete(); tx_q.delete();
  endtask

  // One clock of bench time: log DUT pulses and act as the read-data responder.
  task automatic tick();
    @(negedge clk_in);
    if (str_arm_after) begin
      str_after     = scl;
      str_arm_after = 1'b0;
    end
    tx_valid = 1'b0;
    if (addressed) begin n_addr++; mode_log.push_back(mode); end
    if (rx_valid) rx_log.push_back(data_rx);
    if (stop) n_stop++;
    if (a2_addressed) n_addr2++;
    if (a2_tx_request) n_txreq2++;
    if (tx_request) begin
      n_txreq++;
      resp_cnt = resp_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 100) str_mid = scl;
      if (resp_cnt == 0 && tx_q.size() > 0) begin
        data_tx       = tx_q.pop_front();
        tx_valid      = 1'b1;
        str_before    = scl;
        str_arm_after = 1'b1;
      end
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (scl !== 1'b1 && k < 2000) begin tick(); k++; end
    if (k >= 2000) chk("scl_release_timeout", {31'd0, scl}, 32'd1);
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic rd);
    m_sda_low = ~b;
    if (glitch) begin
      waitn(4); m_scl_low = 1'b0; waitn(2); m_scl_low = 1'b1; waitn(Q - 6);
    end else begin
      waitn(Q);
    end
    m_scl_low = 1'b0;
    wait_scl_high();
    waitn(Q);
    rd = sda;
    waitn(Q);
    m_scl_low = 1'b1;
    waitn(Q);
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0; waitn(Q);
    m_scl_low = 1'b0; wait_scl_high(); waitn(Q);
    m_sda_low = 1'b1; waitn(Q);
    m_scl_low = 1'b1; waitn(Q);
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; waitn(Q);
    m_scl_low = 1'b0; wait_scl_high(); waitn(Q);
    m_sda_low = 1'b0; waitn(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic ack);
    logic rd;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], (i == glitch_at), rd);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic ackbit, output logic [7:0] d);
    logic rd;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, 1'b0, rd);
      d = {d[6:0], rd};
    end
    clock_bit(ackbit, 1'b0, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] b;
    logic       rd;
    reset = 1'b1; data_tx = 8'h00; tx_valid = 1'b0; resp_delay = 3;
    clear();
    waitn(3);
    chk("reset_outs", {addressed, mode, data_rx, rx_valid, tx_request, nack, stop, busy}, 0);
    chk("reset_lines", {scl, sda}, 2'b11);
    reset = 1'b0;
    waitn(20);
    chk("idle_busy", busy, 0);

    // Read 0x96 (ACK) then 0x0F (NACK)
    clear(); resp_delay = 3; tx_q.push_back(8'h96); tx_q.push_back(8'h0F);
    start_cond();
    chk("busy_start", busy, 1);
    write_byte(8'hA1, -1, ack); chk("rd_addr_ack", ack, 0);
    read_byte(1'b0, b); chk("rd_byte0", b, 8'h96);
    read_byte(1'b1, b); chk("rd_byte1", b, 8'h0F);
    stop_cond();
    chk("rd_nack", nack, 1);
    chk("rd_txreq", n_txreq, 2);
    chk("rd_mode", mode, 1);

    // Write 0xA5, 0x3C
    clear();
    start_cond();
    write_byte(8'hA0, -1, ack); chk("wr_addr_ack", ack, 0);
    write_byte(8'hA5, -1, ack); chk("wr_ack0", ack, 0);
    write_byte(8'h3C, -1, ack); chk("wr_ack1", ack, 0);
    stop_cond();
    chk("wr_addressed", n_addr, 1);
    chk("wr_mode", mode, 0);
    chk("wr_rx_cnt", rx_log.size(), 2);
    chk("wr_rx0", rx_log[0], 8'hA5);
    chk("wr_rx1", rx_log[1], 8'h3C);
    chk("wr_stop", n_stop, 1);
    chk("wr_busy_end", busy, 0);
    chk("wr_other_quiet", n_addr2, 0);

    // Address 0x51 is not ours
    clear();
    start_cond();
    write_byte(8'hA2, -1, ack); chk("mm_addr_nack", ack, 1);
    write_byte(8'h11, -1, ack); chk("mm_data_nack", ack, 1);
    stop_cond();
    chk("mm_events", n_addr + rx_log.size() + n_stop, 0);

    // Late read data with stretching
    clear(); resp_delay = 200; tx_q.push_back(8'hC3);
    str_mid = 1'b1; str_before = 1'b1; str_after = 1'b0;
    start_cond();
    write_byte(8'hA1, -1, ack); chk("st_addr_ack", ack, 0);
    read_byte(1'b1, b);
    stop_cond();
    chk("st_data", b, 8'hC3);
    chk("st_scl_mid", str_mid, 0);
    chk("st_scl_at_valid", str_before, 0);
    chk("st_scl_after", str_after, 1);

    // Late read data without stretching (target 0x2A never gets tx_valid)
    clear();
    start_cond();
    write_byte(8'h55, -1, ack); chk("cs0_addr_ack", ack, 0);
    read_byte(1'b1, b);
    stop_cond();
    chk("cs0_data", b, 8'hFF);
    chk("cs0_txreq", n_txreq2, 1);
    chk("cs0_dut1_quiet", n_addr, 0);

    // Write 0x10, repeated START, read 0x5A
    clear(); resp_delay = 2; tx_q.push_back(8'h5A);
    start_cond();
    write_byte(8'hA0, -1, ack); chk("sr_wr_ack", ack, 0);
    write_byte(8'h10, -1, ack);
    start_cond();
    chk("sr_no_stop", n_stop, 0);
    write_byte(8'hA1, -1, ack); chk("sr_rd_ack", ack, 0);
    read_byte(1'b1, b);
    stop_cond();
    chk("sr_addressed", n_addr, 2);
    chk("sr_modes", {mode_log[0], mode_log[1]}, 2'b01);
    chk("sr_rx", rx_log[0], 8'h10);
    chk("sr_data", b, 8'h5A);

    // Two-cycle SCL glitch inside a data byte
    clear();
    start_cond();
    write_byte(8'hA0, -1, ack);
    write_byte(8'hB7, 4, ack); chk("gl_ack", ack, 0);
    stop_cond();
    chk("gl_rx_cnt", rx_log.size(), 1);
    chk("gl_rx", rx_log[0], 8'hB7);

    // Reset in the middle of a read byte of 0x00
    clear(); resp_delay = 2; tx_q.push_back(8'h00);
    start_cond();
    write_byte(8'hA1, -1, ack);
    repeat (3) clock_bit(1'b1, 1'b0, rd);
    chk("rst_pre_sda", sda, 0);
    chk("rst_pre_busy", busy, 1);
    m_scl_low = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_lines", {scl, sda}, 2'b11);
    chk("rst_outs", {addressed, mode, data_rx, rx_valid, tx_request, nack, stop, busy}, 0);
    waitn(5);
    reset = 1'b0;
    waitn(50);
    chk("rst_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
